// File: rtl/uart_crc_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_crc_rx
// Purpose  : UART receiver for frames of start, DATA_W data bits, CRC_W CRC
//            bits (both LSB first) and a stop bit, with CRC check and a
//            one-entry valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_crc_rx #(
   parameter int               CLKS_PER_BIT = 1042,
   parameter int               DATA_W       = 8,
   parameter int               CRC_W        = 4,
   parameter logic [CRC_W-1:0] CRC_POLY     = 4'h3,
   parameter logic [CRC_W-1:0] CRC_INIT     = 4'h0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              crc_error,
   output logic              frame_error,
   output logic              overrun,
   output logic              busy
);

   localparam int c_CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int c_BITS_MAX = (DATA_W > CRC_W) ? DATA_W : CRC_W;
   localparam int c_BIT_W    = (c_BITS_MAX > 1) ? $clog2(c_BITS_MAX) : 1;

   localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_W - 1);
   localparam logic [c_BIT_W-1:0] c_CRC_LAST  = c_BIT_W'(CRC_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_CRC   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   state_t              r_state, w_state;
   logic                r_rx_meta, r_rxs;
   logic [c_CNT_W-1:0]  r_clk_cnt, w_clk_cnt;
   logic [c_BIT_W-1:0]  r_bit_cnt, w_bit_cnt;
   logic [DATA_W-1:0]   r_data_sr, w_data_sr;
   logic [CRC_W-1:0]    r_rx_crc, w_rx_crc;
   logic [CRC_W-1:0]    r_crc, w_crc;
   logic [DATA_W-1:0]   r_data_out, w_data_out;
   logic                r_out_valid, w_out_valid;
   logic                r_crc_error, w_crc_error;
   logic                r_frame_error, w_frame_error;
   logic                r_overrun, w_overrun;

   logic                w_bit_tick;
   logic                w_fb;
   logic [CRC_W-1:0]    w_crc_step;
   logic [DATA_W-1:0]   w_data_bit;
   logic [CRC_W-1:0]    w_crc_bit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta     <= 1'b1;
         r_rxs         <= 1'b1;
         r_state       <= S_IDLE;
         r_clk_cnt     <= '0;
         r_bit_cnt     <= '0;
         r_data_sr     <= '0;
         r_rx_crc      <= '0;
         r_crc         <= CRC_INIT;
         r_data_out    <= '0;
         r_out_valid   <= 1'b0;
         r_crc_error   <= 1'b0;
         r_frame_error <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_rx_meta     <= rx;
         r_rxs         <= r_rx_meta;
         r_state       <= w_state;
         r_clk_cnt     <= w_clk_cnt;
         r_bit_cnt     <= w_bit_cnt;
         r_data_sr     <= w_data_sr;
         r_rx_crc      <= w_rx_crc;
         r_crc         <= w_crc;
         r_data_out    <= w_data_out;
         r_out_valid   <= w_out_valid;
         r_crc_error   <= w_crc_error;
         r_frame_error <= w_frame_error;
         r_overrun     <= w_overrun;
      end
   end

   always_comb begin
      w_state       = r_state;
      w_clk_cnt     = r_clk_cnt;
      w_bit_cnt     = r_bit_cnt;
      w_data_sr     = r_data_sr;
      w_rx_crc      = r_rx_crc;
      w_crc         = r_crc;
      w_data_out    = r_data_out;
      w_out_valid   = r_out_valid;
      w_crc_error   = r_crc_error;
      w_frame_error = 1'b0;
      w_overrun     = r_overrun;

      w_bit_tick = (r_clk_cnt == c_FULL);
      // New bits enter at the MSB so the first bit received ends up at bit 0.
      w_data_bit             = '0;
      w_data_bit[DATA_W-1]   = r_rxs;
      w_crc_bit              = '0;
      w_crc_bit[CRC_W-1]     = r_rxs;
      w_fb       = r_crc[CRC_W-1] ^ r_rxs;
      w_crc_step = (r_crc << 1) ^ (w_fb ? CRC_POLY : '0);

      if (r_out_valid && out_ready) begin
         w_out_valid = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (!r_rxs) begin
               w_state   = S_START;
               w_clk_cnt = '0;
               w_bit_cnt = '0;
               w_crc     = CRC_INIT;
            end
         end
         S_START: begin
            if (r_clk_cnt == c_HALF) begin
               w_clk_cnt = '0;
               w_state   = r_rxs ? S_IDLE : S_DATA;
            end else begin
               w_clk_cnt = r_clk_cnt + c_CNT_W'(1);
            end
         end
         S_DATA: begin
            if (w_bit_tick) begin
               w_clk_cnt = '0;
               w_data_sr = (r_data_sr >> 1) | w_data_bit;
               w_crc     = w_crc_step;
               if (r_bit_cnt == c_DATA_LAST) begin
                  w_bit_cnt = '0;
                  w_state   = S_CRC;
               end else begin
                  w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
               end
            end else begin
               w_clk_cnt = r_clk_cnt + c_CNT_W'(1);
            end
         end
         S_CRC: begin
            if (w_bit_tick) begin
               w_clk_cnt = '0;
               w_rx_crc  = (r_rx_crc >> 1) | w_crc_bit;
               if (r_bit_cnt == c_CRC_LAST) begin
                  w_bit_cnt = '0;
                  w_state   = S_STOP;
               end else begin
                  w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
               end
            end else begin
               w_clk_cnt = r_clk_cnt + c_CNT_W'(1);
            end
         end
         S_STOP: begin
            if (w_bit_tick) begin
               w_clk_cnt = '0;
               w_state   = S_IDLE;
               if (r_rxs) begin
                  // A frame may load on the same edge the held one is taken.
                  if (!r_out_valid || out_ready) begin
                     w_data_out  = r_data_sr;
                     w_crc_error = (r_rx_crc != r_crc);
                     w_out_valid = 1'b1;
                  end else begin
                     w_overrun = 1'b1;
                  end
               end else begin
                  w_frame_error = 1'b1;
               end
            end else begin
               w_clk_cnt = r_clk_cnt + c_CNT_W'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   assign data_out    = r_data_out;
   assign out_valid   = r_out_valid;
   assign crc_error   = r_crc_error;
   assign frame_error = r_frame_error;
   assign overrun     = r_overrun;
   assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_crc_rx.sv
`default_nettype none
// Testbench for uart_crc_rx: serial frame driver, delivered-frame monitor and
// an expected-result queue compared inside each scenario task.
module tb_uart_crc_rx;

   localparam int CLKS = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       out_ready;
   logic [7:0] data_out;
   logic       out_valid;
   logic       crc_error;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         fe_cycles   = 0;
   int         busy_cycles = 0;

   always #5 clk = ~clk;

   uart_crc_rx #(
      .CLKS_PER_BIT(CLKS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .crc_error  (crc_error),
      .frame_error(frame_error),
      .overrun    (overrun),
      .busy       (busy)
   );

   // Inputs change 1 ns after posedge, so at negedge they are stable for the coming edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) obs_q.push_back({crc_error, data_out});
      if (frame_error) fe_cycles = fe_cycles + 1;
      if (busy) busy_cycles = busy_cycles + 1;
   end

   function automatic logic [3:0] crc_calc(input logic [7:0] d);
      logic [3:0] c;
      logic       fb;
      c = 4'h0;
      for (int i = 0; i < 8; i++) begin
         fb = c[3] ^ d[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
      end
      return c;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input int n);
      rx = b;
      tick(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [3:0] c, input logic stop);
      send_bit(1'b0, CLKS);
      for (int i = 0; i < 8; i++) send_bit(d[i], CLKS);
      for (int i = 0; i < 4; i++) send_bit(c[i], CLKS);
      if (stop) begin
         send_bit(1'b1, CLKS);
      end else begin
         send_bit(1'b0, 12);
         send_bit(1'b1, 2 * CLKS);
      end
   endtask

   task automatic wait_obs(input int n, input string name);
      int k = 0;
      while (obs_q.size() < n && k < 40 * CLKS) begin
         tick(1);
         k++;
      end
      total++;
      if (obs_q.size() < n) begin
         bad++;
         $display("FAIL %s_timeout: frames seen=%0d required=%0d", name, obs_q.size(), n);
      end
   endtask

   task automatic drain_compare(input string name);
      logic [8:0] e, o;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL %s: got crc_err=%b data=%h, required crc_err=%b data=%h",
                     name, o[8], o[7:0], e[8], e[7:0]);
         end
      end
      total++;
      if (obs_q.size() != 0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_count: leftover observed=%0d expected=%0d", name, obs_q.size(), exp_q.size());
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      total++;
      if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h required 00", data_out); end
      total++;
      if (crc_error !== 1'b0) begin bad++; $display("FAIL reset_crc_error: got %b required 0", crc_error); end
      total++;
      if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error: got %b required 0", frame_error); end
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b required 0", overrun); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
   endtask

   task automatic test_good_frame();
      int fe0 = fe_cycles;
      exp_q.push_back({1'b0, 8'h3F});
      send_frame(8'h3F, 4'h1, 1'b1);
      wait_obs(1, "good_frame");
      tick(2);
      drain_compare("good_frame");
      total++;
      if (fe_cycles != fe0) begin bad++; $display("FAIL good_frame_fe: got %0d pulses required 0", fe_cycles - fe0); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL good_frame_drained: out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_crc_error();
      exp_q.push_back({1'b1, 8'h3F});
      send_frame(8'h3F, 4'h5, 1'b1);
      wait_obs(1, "crc_bad_crc");
      drain_compare("crc_bad_crc");
      exp_q.push_back({1'b1, 8'h3B});
      send_frame(8'h3B, 4'h1, 1'b1);
      wait_obs(1, "crc_bad_data");
      drain_compare("crc_bad_data");
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic [3:0] c;
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom_range(0, 255));
         c = crc_calc(d);
         if (i == 3) c = c ^ 4'h8;
         exp_q.push_back({(i == 3), d});
         send_frame(d, c, 1'b1);
      end
      wait_obs(4, "back_to_back");
      drain_compare("back_to_back");
   endtask

   task automatic test_frame_error();
      int fe0 = fe_cycles;
      send_frame(8'h00, 4'h0, 1'b0);
      tick(CLKS);
      total++;
      if (fe_cycles - fe0 != 1) begin bad++; $display("FAIL frame_error_pulse: got %0d cycles required 1", fe_cycles - fe0); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL frame_error_valid: got %b required 0", out_valid); end
      total++;
      if (obs_q.size() != 0) begin bad++; $display("FAIL frame_error_delivered: got %0d frames required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_glitch();
      int b0  = busy_cycles;
      int fe0 = fe_cycles;
      send_bit(1'b0, 4);
      send_bit(1'b1, 3 * CLKS);
      total++;
      if (busy_cycles - b0 < 1 || busy_cycles - b0 > CLKS / 2) begin
         bad++;
         $display("FAIL glitch_busy: got %0d busy cycles required 1..%0d", busy_cycles - b0, CLKS / 2);
      end
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || fe_cycles != fe0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL glitch_flags: got busy=%b valid=%b fe=%0d ovr=%b required all 0",
                  busy, out_valid, fe_cycles - fe0, overrun);
      end
   endtask

   task automatic test_overrun();
      out_ready = 1'b0;
      exp_q.push_back({1'b0, 8'hA5});
      send_frame(8'hA5, crc_calc(8'hA5), 1'b1);
      send_frame(8'h5A, crc_calc(8'h5A), 1'b1);
      tick(4);
      total++;
      if (out_valid !== 1'b1 || data_out !== 8'hA5 || crc_error !== 1'b0) begin
         bad++;
         $display("FAIL overrun_held: got valid=%b data=%h crc_err=%b required 1 a5 0", out_valid, data_out, crc_error);
      end
      total++;
      if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag: got %b required 1", overrun); end
      out_ready = 1'b1;
      tick(5);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL overrun_release: out_valid=%b required 0", out_valid); end
      drain_compare("overrun_transfer");
      total++;
      if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b required 1", overrun); end
   endtask

   task automatic test_reset_mid();
      send_bit(1'b0, CLKS);
      send_bit(1'b1, CLKS);
      send_bit(1'b0, CLKS / 2);
      rst = 1'b1;
      rx  = 1'b1;
      tick(1);
      total++;
      if (busy !== 1'b0 || overrun !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h00 ||
          crc_error !== 1'b0 || frame_error !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got busy=%b ovr=%b valid=%b data=%h crc=%b fe=%b required all 0",
                  busy, overrun, out_valid, data_out, crc_error, frame_error);
      end
      rst = 1'b0;
      tick(3 * CLKS);
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_abandon: got valid=%b busy=%b required 0 0", out_valid, busy);
      end
      exp_q.push_back({1'b0, 8'h00});
      send_frame(8'h00, 4'h0, 1'b1);
      wait_obs(1, "after_reset");
      drain_compare("after_reset");
   endtask

   initial begin
      rst       = 1'b1;
      rx        = 1'b1;
      out_ready = 1'b1;
      tick(5);
      test_reset();
      rst = 1'b0;
      tick(3);
      test_good_frame();
      test_crc_error();
      test_back_to_back();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/uart_crc_rx.md
Name: uart_crc_rx

Overview:
- Parametrised UART receiver with CRC check; successor to the fixed 8-data/4-CRC receive path inside uart_top.
- Deserialises frames of the form: start bit, DATA_W data bits LSB-first, CRC_W CRC bits LSB-first, stop bit.
- Recomputes the CRC over the received data bits and delivers each frame through a valid/ready handshake with a one-entry holding register.
- Reports CRC, framing and overrun errors as per-frame flags.

Parameters:
- CLKS_PER_BIT, 1042: clocks per bit period (10 MHz / 9600 baud); minimum 4.
- DATA_W, 8: data bits per frame; range 1..32.
- CRC_W, 4: CRC width; range 1..16.
- CRC_POLY, 4'h3: generator polynomial, implicit top bit (x^4+x+1 by default); width CRC_W.
- CRC_INIT, 4'h0: CRC register seed at the start of each frame; width CRC_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  DATA_W  received data, held stable while out_valid=1.
- out_valid  out  1  holding register contains an undelivered frame.
- out_ready  in  1  consumer accepts; the transfer occurs on a clk edge with out_valid&&out_ready.
- crc_error  out  1  qualifies data_out; 1 = received CRC != computed CRC.
- frame_error  out  1  one-cycle pulse when the stop bit samples 0.
- overrun  out  1  sticky; set when a completed frame is lost because the holding register was full; cleared only by rst.
- busy  out  1  high from start-bit detect to end of stop bit.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE; data_out=0; out_valid=0; crc_error=0; frame_error=0; overrun=0; busy=0. The synchroniser flops are set to 1.
  - A reset mid-frame abandons the frame; no output is produced.
- rx passes through a 2-flop synchroniser. All sampling below uses the synchronised value rxs.
- FSM states: IDLE, START, DATA, CRC, STOP.
  - IDLE: rxs==0 -> START; the bit counter clears and the clock counter clears.
  - START: at clock count CLKS_PER_BIT/2-1 (mid start bit):
    - rxs==0 -> DATA, with the clock counter restarted.
    - rxs==1 -> glitch; return to IDLE with no flags.
  - DATA: every CLKS_PER_BIT clocks, sample rxs into the data shift register, LSB first. After DATA_W samples -> CRC.
  - CRC: same sampling into the received-CRC register, LSB first. After CRC_W samples -> STOP.
  - STOP: sample at mid stop bit, then -> IDLE. The next start bit is accepted immediately.
- CRC engine: advances once per data-bit sample, in reception order. CRC bits are not fed into it.
  - fb = crc[CRC_W-1] ^ bit.
  - crc = {crc[CRC_W-2:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - crc loads CRC_INIT on entry to START.
- Stop sample == 1 (good frame), evaluated on the STOP sample edge:
  - If out_valid==0, or out_valid&&out_ready on that same edge: load data_out, set crc_error = (rx_crc != crc), set out_valid=1.
  - Otherwise: drop the frame, set overrun=1, leave the held frame untouched.
- Stop sample == 0: pulse frame_error for 1 cycle. The frame is discarded; out_valid and data_out are unchanged.
- out_valid clears on a handshake unless a new frame loads on the same edge, in which case it stays 1 with the new data.
- Latency: out_valid rises 1 clk after the mid-stop-bit sample edge. Synchroniser delay is 2 clk on the start edge.
- data_out and crc_error hold while out_valid=1, regardless of further activity on rx.
- Counters: the clock counter is sized for CLKS_PER_BIT-1; the bit counter for max(DATA_W, CRC_W)-1. There is no wrap other than the reload at bit boundaries.

Test Plan:
- Defaults with CLKS_PER_BIT=16, out_ready=1. Send data 8'h3F, CRC 4'h1 -> out_valid pulse, data_out=8'h3F, crc_error=0, frame_error=0.
- Send data 8'h3F with CRC 4'h5 -> data_out=8'h3F, crc_error=1. Send data 8'h3B with CRC 4'h1 (data bit error) -> crc_error=1.
- Stop bit driven 0 on an otherwise valid 8'h00/4'h0 frame -> frame_error high 1 cycle, out_valid stays 0.
- Start glitch: rx low for 4 clocks then high -> no busy beyond the half bit, no out_valid, no flags.
- out_ready=0, send two valid frames (8'hA5 then 8'h5A) -> out_valid=1 with data_out=8'hA5 held, overrun=1. Raise out_ready -> one transfer of 8'hA5, then out_valid=0.
- Assert rst mid-DATA of a frame -> all outputs 0 next cycle. Then send 8'h00/CRC 4'h0 -> received cleanly with crc_error=0.
